// File: rtl/decode.sv
// Tachyon decode stage: a 2-entry queue absorbs the fetch stream (fetch cannot stall),
// and each RV32I instruction is decoded into class/registers/immediate in the output register.
module decode #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  backend_redirect_valid,
    input  logic                  stage_in_insn_valid,
    input  logic [ADDR_WIDTH-3:0] stage_in_insn_addr,
    input  logic [31:0]           stage_in_insn,
    output logic                  stage_out_valid,
    input  logic                  stage_out_ready,
    output logic [ADDR_WIDTH-3:0] stage_out_addr,
    output logic [31:0]           stage_out_insn,
    output logic [3:0]            stage_out_class,
    output logic [4:0]            stage_out_rd,
    output logic [4:0]            stage_out_rs1,
    output logic [4:0]            stage_out_rs2,
    output logic [2:0]            stage_out_funct3,
    output logic                  stage_out_alt,
    output logic [31:0]           stage_out_imm,
    output logic                  overflow_err
);
    localparam int AW = ADDR_WIDTH - 2;

    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_OPIMM   = 4'd7,
        CLS_OP      = 4'd8,
        CLS_FENCE   = 4'd9,
        CLS_SYSTEM  = 4'd10,
        CLS_ILLEGAL = 4'd15
    } insn_class_t;

    // Queue storage
    logic [AW-1:0] q_addr_reg [2];
    logic [31:0]   q_insn_reg [2];
    logic          q_rd_ptr_reg;
    logic          q_wr_ptr_reg;
    logic [1:0]    q_cnt_reg;

    // Output register
    logic          out_valid_reg;
    logic [AW-1:0] out_addr_reg;
    logic [31:0]   out_insn_reg;
    logic [3:0]    out_class_reg;
    logic [4:0]    out_rd_reg;
    logic [4:0]    out_rs1_reg;
    logic [4:0]    out_rs2_reg;
    logic [2:0]    out_funct3_reg;
    logic          out_alt_reg;
    logic [31:0]   out_imm_reg;
    logic          overflow_reg;

    logic          q_empty, q_full, fire, or_load, q_pop, bypass, push_req, q_push, overflow_set;
    logic          src_valid;
    logic [AW-1:0] src_addr;
    logic [31:0]   src_insn;

    assign q_empty  = (q_cnt_reg == 2'd0);
    assign q_full   = (q_cnt_reg == 2'd2);
    assign fire     = out_valid_reg & stage_out_ready;
    assign or_load  = ~out_valid_reg | fire;
    assign q_pop    = or_load & ~q_empty;
    // Bypass only when the queue is empty, so ordering is never violated.
    assign bypass   = or_load & q_empty & stage_in_insn_valid;
    assign push_req = stage_in_insn_valid & ~bypass;
    assign q_push   = push_req & (~q_full | q_pop) & ~backend_redirect_valid;
    assign overflow_set = push_req & q_full & ~q_pop & ~backend_redirect_valid;

    assign src_valid = ~q_empty | stage_in_insn_valid;
    assign src_addr  = q_empty ? stage_in_insn_addr : q_addr_reg[q_rd_ptr_reg];
    assign src_insn  = q_empty ? stage_in_insn      : q_insn_reg[q_rd_ptr_reg];

    // Decode of the OR load source
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        opimm_ok, op_ok;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    insn_class_t dec_class;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic        dec_alt;
    logic [31:0] dec_imm;

    assign opc   = src_insn[6:0];
    assign f3    = src_insn[14:12];
    assign f7    = src_insn[31:25];
    assign imm_i = {{20{src_insn[31]}}, src_insn[31:20]};
    assign imm_s = {{20{src_insn[31]}}, src_insn[31:25], src_insn[11:7]};
    assign imm_b = {{19{src_insn[31]}}, src_insn[31], src_insn[7], src_insn[30:25], src_insn[11:8], 1'b0};
    assign imm_u = {src_insn[31:12], 12'h000};
    assign imm_j = {{11{src_insn[31]}}, src_insn[31], src_insn[19:12], src_insn[20], src_insn[30:21], 1'b0};
    assign opimm_ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                      (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
    assign op_ok    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));

    always_comb begin
        dec_class = CLS_ILLEGAL;
        dec_rd    = '0;
        dec_rs1   = '0;
        dec_rs2   = '0;
        dec_alt   = 1'b0;
        dec_imm   = '0;
        if (opc[1:0] == 2'b11) begin
            unique case (opc[6:2])
                5'b01101: begin dec_class = CLS_LUI;   dec_rd = src_insn[11:7]; dec_imm = imm_u; end
                5'b00101: begin dec_class = CLS_AUIPC; dec_rd = src_insn[11:7]; dec_imm = imm_u; end
                5'b11011: begin dec_class = CLS_JAL;   dec_rd = src_insn[11:7]; dec_imm = imm_j; end
                5'b11001: if (f3 == 3'd0) begin
                    dec_class = CLS_JALR; dec_rd = src_insn[11:7]; dec_rs1 = src_insn[19:15]; dec_imm = imm_i;
                end
                5'b11000: if (f3 != 3'd2 && f3 != 3'd3) begin
                    dec_class = CLS_BRANCH; dec_rs1 = src_insn[19:15]; dec_rs2 = src_insn[24:20]; dec_imm = imm_b;
                end
                5'b00000: if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) begin
                    dec_class = CLS_LOAD; dec_rd = src_insn[11:7]; dec_rs1 = src_insn[19:15]; dec_imm = imm_i;
                end
                5'b01000: if (f3 <= 3'd2) begin
                    dec_class = CLS_STORE; dec_rs1 = src_insn[19:15]; dec_rs2 = src_insn[24:20]; dec_imm = imm_s;
                end
                5'b00100: if (opimm_ok) begin
                    dec_class = CLS_OPIMM; dec_rd = src_insn[11:7]; dec_rs1 = src_insn[19:15]; dec_imm = imm_i;
                    dec_alt   = (f3 == 3'd5) & src_insn[30];
                end
                5'b01100: if (op_ok) begin
                    dec_class = CLS_OP; dec_rd = src_insn[11:7]; dec_rs1 = src_insn[19:15]; dec_rs2 = src_insn[24:20];
                    dec_alt   = src_insn[30];
                end
                5'b00011: begin dec_class = CLS_FENCE;  dec_rd = src_insn[11:7]; dec_rs1 = src_insn[19:15]; dec_imm = imm_i; end
                5'b11100: begin dec_class = CLS_SYSTEM; dec_rd = src_insn[11:7]; dec_rs1 = src_insn[19:15]; dec_imm = imm_i; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_addr_reg[0] <= '0;
            q_addr_reg[1] <= '0;
            q_insn_reg[0] <= '0;
            q_insn_reg[1] <= '0;
            q_rd_ptr_reg  <= 1'b0;
            q_wr_ptr_reg  <= 1'b0;
            q_cnt_reg     <= 2'd0;
            overflow_reg  <= 1'b0;
        end else if (backend_redirect_valid) begin
            q_rd_ptr_reg <= 1'b0;
            q_wr_ptr_reg <= 1'b0;
            q_cnt_reg    <= 2'd0;
        end else begin
            if (q_push) begin
                q_addr_reg[q_wr_ptr_reg] <= stage_in_insn_addr;
                q_insn_reg[q_wr_ptr_reg] <= stage_in_insn;
                q_wr_ptr_reg             <= ~q_wr_ptr_reg;
            end
            if (q_pop) q_rd_ptr_reg <= ~q_rd_ptr_reg;
            if (q_push && !q_pop)      q_cnt_reg <= q_cnt_reg + 2'd1;
            else if (!q_push && q_pop) q_cnt_reg <= q_cnt_reg - 2'd1;
            if (overflow_set) overflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_addr_reg   <= '0;
            out_insn_reg   <= '0;
            out_class_reg  <= '0;
            out_rd_reg     <= '0;
            out_rs1_reg    <= '0;
            out_rs2_reg    <= '0;
            out_funct3_reg <= '0;
            out_alt_reg    <= 1'b0;
            out_imm_reg    <= '0;
        end else if (backend_redirect_valid) begin
            out_valid_reg <= 1'b0;
        end else if (or_load) begin
            out_valid_reg <= src_valid;
            if (src_valid) begin
                out_addr_reg   <= src_addr;
                out_insn_reg   <= src_insn;
                out_class_reg  <= dec_class;
                out_rd_reg     <= dec_rd;
                out_rs1_reg    <= dec_rs1;
                out_rs2_reg    <= dec_rs2;
                out_funct3_reg <= f3;
                out_alt_reg    <= dec_alt;
                out_imm_reg    <= dec_imm;
            end
        end
    end

    assign stage_out_valid  = out_valid_reg;
    assign stage_out_addr   = out_addr_reg;
    assign stage_out_insn   = out_insn_reg;
    assign stage_out_class  = out_class_reg;
    assign stage_out_rd     = out_rd_reg;
    assign stage_out_rs1    = out_rs1_reg;
    assign stage_out_rs2    = out_rs2_reg;
    assign stage_out_funct3 = out_funct3_reg;
    assign stage_out_alt    = out_alt_reg;
    assign stage_out_imm    = out_imm_reg;
    assign overflow_err     = overflow_reg;
endmodule

// File: doc/decode.md
# decode

Instruction decode stage of the Tachyon core, directly downstream of the fetch stage. It consumes the fetch stage's registered instruction stream (valid, word address, 32-bit RV32I instruction) and absorbs it in a 2-entry queue, because fetch has no backpressure input. It decodes each instruction into register indices, a sign-extended immediate and an instruction class, and presents the result to execute through a registered valid/ready output. Backend redirects flush all in-flight state.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width; addresses carried as word addresses [ADDR_WIDTH-1:2]

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock
- rst  in  1  async active-high reset
- backend_redirect_valid  in  1  flush all queued and output instructions
- stage_in_insn_valid  in  1  instruction from fetch valid this cycle
- stage_in_insn_addr  in  ADDR_WIDTH-2  word address of instruction
- stage_in_insn  in  32  raw instruction
- stage_out_valid  out  1  decoded instruction valid
- stage_out_ready  in  1  execute accepts stage_out this cycle
- stage_out_addr  out  ADDR_WIDTH-2  word address
- stage_out_insn  out  32  raw instruction (passed through)
- stage_out_class  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OPIMM, 8 OP, 9 FENCE, 10 SYSTEM, 15 ILLEGAL
- stage_out_rd, stage_out_rs1, stage_out_rs2  out  5 each  register indices (0 where the format has no such field)
- stage_out_funct3  out  3  insn[14:12]
- stage_out_alt  out  1  insn[30] for OP and for OPIMM funct3=5, else 0
- stage_out_imm  out  32  sign-extended immediate per format (I/S/B/U/J), 0 for R-type
- overflow_err  out  1  sticky: instruction arrived with no free slot

## Operation
- Storage: one output register (OR) plus a 2-entry FIFO (Q) holding raw addr+insn. Total capacity 3.
- Output fire = stage_out_valid & stage_out_ready.
- Each cycle, OR is loaded if it is empty or firing: the source is the Q head if Q is non-empty, else stage_in (bypass) if valid. Otherwise OR holds.
- stage_in is enqueued when valid and not consumed by bypass. Order is strictly preserved: bypass only when Q is empty.
- Push to a full Q with no pop in that cycle: the instruction is dropped and overflow_err is set (cleared only by rst). Push and pop in the same cycle with Q full is legal.
- Decode is combinational on the OR load source and is registered into OR with it.
- ILLEGAL class:
  - insn[1:0] != 2'b11 or an unknown opcode;
  - JALR funct3 != 0;
  - BRANCH funct3 2 or 3;
  - LOAD funct3 3, 6 or 7;
  - STORE funct3 > 2;
  - OP funct7 not 0x00/0x20, or 0x20 with funct3 not 0/5;
  - OPIMM shift with bad funct7 (funct3=1 needs 0x00; funct3=5 needs 0x00 or 0x20).
- ILLEGAL outputs: rd, rs1 and rs2 forced to 0, imm 0, insn still passed through.
- Flush: backend_redirect_valid at an edge clears OR valid and empties Q. A stage_in valid in the same cycle is dropped. The redirect has priority over fire.

## Timing
- Reset values: stage_out_valid 0, all stage_out data 0, Q empty, overflow_err 0. Reset asserted mid-operation discards everything asynchronously.
- Latency: stage_in in cycle N appears on stage_out in cycle N+1 when Q is empty and OR is empty or firing. Otherwise it appears 1 cycle after reaching the Q head and OR freeing.
- Throughput: 1 per cycle with stage_out_ready held high.
- stage_out data is stable while stage_out_valid=1 and stage_out_ready=0.

## Test plan
- addi x1,x0,5 (0x00500093) at addr 0x40, ready=1 -> next cycle valid, class 7, rd 1, rs1 0, imm 0x00000005, addr 0x40.
- lui x2,0x12345 (0x12345137) -> class 0, rd 2, imm 0x12345000; beq x0,x0,-4 (0xFE000EE3) -> class 4, imm 0xFFFFFFFC, rd 0.
- ready=0, push 3 back-to-back insns -> OR holds #1, Q full, overflow_err 0; 4th push -> overflow_err=1, 4th dropped; ready=1 -> #1, #2, #3 emitted in order on consecutive cycles.
- Q holding 2 plus OR valid, then redirect_valid=1 with stage_in valid -> next cycle stage_out_valid=0, Q empty; the following input bypasses with 1-cycle latency.
- 0x00000000, sub-type with funct7 0x40 (0x8000_00B3), and LOAD funct3=3 -> class 15, imm 0.
- Async rst asserted between clock edges with data in flight -> stage_out_valid drops immediately, all outputs 0.
